// File: rtl/calibration_step_seq.sv
// LED calibration step sequencer: settle, frame sync, then one downsampled capture frame issued
// as shift-accumulate requests. Optional valid-pixel counter under `define CALIB_PIXEL_COUNT_EN.
module calibration_step_seq #(
  parameter int DETECT_CHANNELS = 2,
  parameter int NUM_STEPS       = 10,
  parameter int WAIT_CYCLES     = 10000000,
  parameter int FRAME_TIMEOUT   = 2000000,
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int ACTIVE_LINES    = 720,
  parameter int DS_SHIFT        = 2,
  localparam int SYM_W  = (DETECT_CHANNELS > 1) ? $clog2(DETECT_CHANNELS) : 1,
  localparam int ADDR_W = $clog2((ACTIVE_H_PIXELS >> DS_SHIFT) * (ACTIVE_LINES >> DS_SHIFT)),
  localparam int SI_W   = $clog2(NUM_STEPS + 1)
) (
  input  logic                       clk_pixel,
  input  logic                       rst,
  input  logic                       start_step,
  input  logic                       restart,
  input  logic [10:0]                hcount_in,
  input  logic [9:0]                 vcount_in,
  input  logic                       new_frame_in,
  input  logic [DETECT_CHANNELS-1:0] detect_in,
  input  logic                       read_request,
  input  logic [ADDR_W-1:0]          read_addr,
  output logic [2:0]                 state,
  output logic [SI_W-1:0]            step_index,
  output logic                       step_done,
  output logic                       calib_complete,
  output logic                       timeout_err,
  output logic                       req_valid,
  output logic [1:0]                 req_type,
  output logic [ADDR_W-1:0]          req_addr,
  output logic [SYM_W-1:0]           req_symbol,
  output logic                       read_dropped
`ifdef CALIB_PIXEL_COUNT_EN
  ,
  output logic [ADDR_W:0]            valid_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SETTLE = 3'd1, S_WAIT = 3'd2, S_CAPTURE = 3'd3, S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] T_READ = 2'd0, T_WRITE = 2'd1, T_WOVER = 2'd2, T_DIS = 2'd3;
  localparam int CNT_MAX = (WAIT_CYCLES > FRAME_TIMEOUT) ? WAIT_CYCLES : FRAME_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int H_DS    = ACTIVE_H_PIXELS >> DS_SHIFT;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(FRAME_TIMEOUT - 1);
  localparam logic [10:0] H_MASK = 11'((1 << DS_SHIFT) - 1);
  localparam logic [9:0]  V_MASK = 10'((1 << DS_SHIFT) - 1);

  state_t st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SI_W-1:0]  step_n;
  logic start_q, start_rise, tout_n, cmpl_n, done_n;
  logic active, samp, onehot;
  logic [ADDR_W-1:0] samp_addr;
  logic [SYM_W-1:0]  sym_idx;

  assign state      = st;
  assign start_rise = start_step & ~start_q;
  assign active     = (hcount_in < 11'(ACTIVE_H_PIXELS)) && (vcount_in < 10'(ACTIVE_LINES));
  assign samp       = active && ((hcount_in & H_MASK) == '0) && ((vcount_in & V_MASK) == '0);
  assign samp_addr  = ADDR_W'(hcount_in >> DS_SHIFT) + ADDR_W'(H_DS * int'(vcount_in >> DS_SHIFT));
  assign onehot     = $onehot(detect_in);

  always_comb begin
    sym_idx = '0;
    for (int i = 0; i < DETECT_CHANNELS; i++)
      if (detect_in[i]) sym_idx = SYM_W'(i);
  end

  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    tout_n = timeout_err;
    step_n = step_index;
    cmpl_n = calib_complete;
    done_n = 1'b0;
    case (st)
      S_IDLE: begin
        if (restart) begin
          step_n = '0;
          cmpl_n = 1'b0;
        end
        // start gating uses the registered completion flag, so restart+start acts as restart only
        if (start_rise && !calib_complete) begin
          st_n   = S_SETTLE;
          cnt_n  = '0;
          tout_n = 1'b0;
        end
      end
      S_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          st_n  = S_WAIT;
          cnt_n = '0;
        end else cnt_n = cnt + 1'b1;
      end
      S_WAIT: begin
        if (new_frame_in) begin
          st_n  = S_CAPTURE;
          cnt_n = '0;
        end else if (cnt == TO_LAST) begin
          st_n   = S_IDLE;
          tout_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      end
      S_CAPTURE: begin
        if (new_frame_in) begin
          st_n   = S_DONE;
          done_n = 1'b1;
          step_n = step_index + 1'b1;
          cmpl_n = (step_index + 1'b1) == SI_W'(NUM_STEPS);
        end else if (active) cnt_n = '0;
        else if (cnt == TO_LAST) begin
          st_n   = S_IDLE;
          tout_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      end
      S_DONE:  st_n = S_IDLE;
      default: st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      st             <= S_IDLE;
      cnt            <= '0;
      start_q        <= 1'b0;
      step_index     <= '0;
      step_done      <= 1'b0;
      calib_complete <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      st             <= st_n;
      cnt            <= cnt_n;
      start_q        <= start_step;
      step_index     <= step_n;
      step_done      <= done_n;
      calib_complete <= cmpl_n;
      timeout_err    <= tout_n;
    end
  end

  // capture owns the request port; user reads pass through in every other state
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      req_valid    <= 1'b0;
      req_type     <= T_READ;
      req_addr     <= '0;
      req_symbol   <= '0;
      read_dropped <= 1'b0;
    end else if (st == S_CAPTURE) begin
      req_valid    <= samp;
      req_addr     <= samp ? samp_addr : '0;
      req_type     <= !samp ? T_READ : !onehot ? T_DIS : (step_index == '0) ? T_WOVER : T_WRITE;
      req_symbol   <= (samp && onehot) ? sym_idx : '0;
      read_dropped <= read_request;
    end else begin
      req_valid    <= read_request;
      req_type     <= T_READ;
      req_addr     <= read_addr;
      req_symbol   <= '0;
      read_dropped <= 1'b0;
    end
  end

`ifdef CALIB_PIXEL_COUNT_EN
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) valid_count <= '0;
    else if (st == S_WAIT && new_frame_in) valid_count <= '0;
    else if (st == S_CAPTURE && samp && onehot && !(&valid_count)) valid_count <= valid_count + 1'b1;
  end
`endif

endmodule
